// File: rtl/ob_cn_table_ctrl_if.sv
// Conditional order table controller bus.
// Groups intake, entry, and matured-output signals.
interface ob_cn_table_ctrl_if #(
    parameter int N     = 8,
    parameter int CMD_W = 128,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(N+1)
);
    logic               in_vld;
    logic [CMD_W-1:0]   in_cmd;
    logic               in_rdy;
    logic [N-1:0]       al_vld;
    logic [CMD_W-1:0]   al_cmd_r;
    logic [N-1:0]       dl_vld;
    logic [N-1:0]       ent_busy;
    logic [N-1:0]       ent_mtr;
    logic [N*CMD_W-1:0] ent_cmd;
    logic               mtr_vld;
    logic [CMD_W-1:0]   mtr_cmd;
    logic [IDX_W-1:0]   mtr_idx;
    logic               mtr_rdy;
    logic [CNT_W-1:0]   occ;
    logic               full;
    logic               empty;

    modport master (
        output in_vld, in_cmd, ent_busy, ent_mtr, ent_cmd, mtr_rdy,
        input  in_rdy, al_vld, al_cmd_r, dl_vld,
        input  mtr_vld, mtr_cmd, mtr_idx, occ, full, empty
    );

    modport slave (
        input  in_vld, in_cmd, ent_busy, ent_mtr, ent_cmd, mtr_rdy,
        output in_rdy, al_vld, al_cmd_r, dl_vld,
        output mtr_vld, mtr_cmd, mtr_idx, occ, full, empty
    );
endinterface

// File: rtl/ob_cn_table_ctrl.sv
// Conditional order table controller: allocates entries,
// round-robin issues matured commands, then deallocates.
module ob_cn_table_ctrl #(
    parameter int N     = 8,
    parameter int CMD_W = 128,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(N+1)
) (
    input logic           clk,
    input logic           rst_n,
    ob_cn_table_ctrl_if.slave bus
);
    logic [N-1:0]     al_q;
    logic [N-1:0]     dl_q;
    logic [N-1:0]     issued;
    logic [N-1:0]     free;
    logic [N-1:0]     cand;
    logic [CMD_W-1:0] al_cmd_q;
    logic [CMD_W-1:0] mtr_cmd_q;
    logic [CMD_W-1:0] g_cmd;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] mtr_idx_q;
    logic [CNT_W-1:0] occ_q;
    logic             gnt_ok;
    logic             mtr_vld_q;
    logic             full;
    logic             accept;
    logic             hs;
    logic             load;

    assign free   = ~bus.ent_busy & ~al_q;
    assign full   = occ_q == CNT_W'(N);
    assign accept = bus.in_vld & bus.in_rdy;
    assign cand   = bus.ent_mtr & ~issued & ~dl_q;
    assign hs     = mtr_vld_q & bus.mtr_rdy;
    assign load   = (~mtr_vld_q | bus.mtr_rdy) & gnt_ok;
    assign g_cmd  = bus.ent_cmd[int'(gnt)*CMD_W +: CMD_W];

    assign bus.in_rdy   = ~full & (|free);
    assign bus.al_vld   = al_q;
    assign bus.al_cmd_r = al_cmd_q;
    assign bus.dl_vld   = dl_q;
    assign bus.mtr_vld  = mtr_vld_q;
    assign bus.mtr_cmd  = mtr_cmd_q;
    assign bus.mtr_idx  = mtr_idx_q;
    assign bus.occ      = occ_q;
    assign bus.full     = full;
    assign bus.empty    = occ_q == '0;

    // Lowest-index free entry gets the next allocation.
    always_comb begin
        sel = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (free[i]) sel = IDX_W'(i);
        end
    end

    // Round-robin search over matured candidates from ptr.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!gnt_ok && cand[j]) begin
                gnt_ok = 1'b1;
                gnt    = IDX_W'(j);
            end
        end
    end

    // Alloc/dealloc strobes, occupancy, issue tracking, output reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_q      <= '0;
            al_cmd_q  <= '0;
            dl_q      <= '0;
            issued    <= '0;
            occ_q     <= '0;
            ptr       <= '0;
            mtr_vld_q <= 1'b0;
            mtr_cmd_q <= '0;
            mtr_idx_q <= '0;
        end else begin
            al_q <= accept ? (N'(1) << sel) : '0;
            if (accept) al_cmd_q <= bus.in_cmd;
            dl_q <= hs ? (N'(1) << mtr_idx_q) : '0;
            issued <= (issued & ~(hs ? (N'(1) << mtr_idx_q) : '0))
                    | (load ? (N'(1) << gnt) : '0);
            unique case ({accept, |dl_q})
                2'b10: if (!full) occ_q <= occ_q + 1'b1;
                2'b01: if (occ_q != '0) occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            if (load) begin
                mtr_vld_q <= 1'b1;
                mtr_cmd_q <= g_cmd;
                mtr_idx_q <= gnt;
                ptr <= (gnt == IDX_W'(N-1)) ? '0 : gnt + 1'b1;
            end else if (hs) begin
                mtr_vld_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ob_cn_table_ctrl.sv
// Directed bench for ob_cn_table_ctrl with behavioural
// entry models driving busy/matured/command back.
module tb_ob_cn_table_ctrl;
    localparam int N     = 8;
    localparam int CMD_W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_n = 0;
    int   tot_n = 0;

    logic [N-1:0]     busy_q;
    logic [N-1:0]     mtr_q;
    logic [N-1:0]     mset;
    logic [CMD_W-1:0] cmd_q [N];

    ob_cn_table_ctrl_if #(.N(N), .CMD_W(CMD_W)) bus ();

    ob_cn_table_ctrl #(.N(N), .CMD_W(CMD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] mk(int i);
        return {4{32'hA500_0000 + 32'(i)}};
    endfunction

    // Entry models: busy from alloc until the cycle after dealloc.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            mtr_q  <= '0;
        end else begin
            busy_q <= (busy_q | bus.al_vld) & ~bus.dl_vld;
            mtr_q  <= (mtr_q | mset) & ~bus.dl_vld;
            for (int i = 0; i < N; i++)
                if (bus.al_vld[i]) cmd_q[i] <= bus.al_cmd_r;
        end
    end

    assign bus.ent_busy = busy_q | bus.al_vld;
    assign bus.ent_mtr  = mtr_q | mset;

    always_comb begin
        bus.ent_cmd = '0;
        for (int i = 0; i < N; i++)
            bus.ent_cmd[i*CMD_W +: CMD_W] = cmd_q[i];
    end

    task automatic test_reset();
        bus.in_vld = 0; bus.in_cmd = '0; bus.mtr_rdy = 0; mset = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tot_n++;
        if (bus.al_vld !== 8'h00 || bus.dl_vld !== 8'h00)
            $display("FAIL reset_strobes: al=%h dl=%h want 00 00",
                     bus.al_vld, bus.dl_vld);
        else pass_n++;
        tot_n++;
        if (bus.mtr_vld !== 1'b0 || bus.al_cmd_r !== '0)
            $display("FAIL reset_out: mtr_vld=%b al_cmd=%h want 0 0",
                     bus.mtr_vld, bus.al_cmd_r);
        else pass_n++;
        tot_n++;
        if (bus.occ !== 4'd0 || bus.empty !== 1 || bus.full !== 0 ||
            bus.in_rdy !== 1)
            $display("FAIL reset_occ: occ=%0d e=%b f=%b rdy=%b want 0 1 0 1",
                     bus.occ, bus.empty, bus.full, bus.in_rdy);
        else pass_n++;
    endtask

    task automatic test_alloc_first();
        bus.in_vld = 1; bus.in_cmd = mk(0);
        @(negedge clk);
        bus.in_vld = 0;
        tot_n++;
        if (bus.al_vld !== 8'h01 || bus.al_cmd_r !== mk(0))
            $display("FAIL alloc_first: al=%h cmd=%h want 01 %h",
                     bus.al_vld, bus.al_cmd_r, mk(0));
        else pass_n++;
        tot_n++;
        if (bus.occ !== 4'd1 || bus.empty !== 0)
            $display("FAIL alloc_first_occ: occ=%0d e=%b want 1 0",
                     bus.occ, bus.empty);
        else pass_n++;
    endtask

    task automatic test_fill();
        for (int i = 1; i < N; i++) begin
            bus.in_vld = 1; bus.in_cmd = mk(i);
            @(negedge clk);
            tot_n++;
            if (bus.al_vld !== 8'(1 << i) || bus.al_cmd_r !== mk(i))
                $display("FAIL fill_%0d: al=%h want %h", i,
                         bus.al_vld, 8'(1 << i));
            else pass_n++;
        end
        bus.in_vld = 1; bus.in_cmd = mk(99);
        tot_n++;
        if (bus.occ !== 4'd8 || bus.full !== 1 || bus.in_rdy !== 0)
            $display("FAIL fill_full: occ=%0d f=%b rdy=%b want 8 1 0",
                     bus.occ, bus.full, bus.in_rdy);
        else pass_n++;
        @(negedge clk);
        bus.in_vld = 0;
        tot_n++;
        if (bus.al_vld !== 8'h00 || bus.occ !== 4'd8)
            $display("FAIL fill_stall: al=%h occ=%0d want 00 8",
                     bus.al_vld, bus.occ);
        else pass_n++;
    endtask

    task automatic test_rr_pair();
        mset = 8'b0010_0100; bus.mtr_rdy = 1;
        @(negedge clk);
        mset = '0;
        tot_n++;
        if (bus.mtr_vld !== 1 || bus.mtr_idx !== 3'd2 ||
            bus.mtr_cmd !== mk(2))
            $display("FAIL rr_first: vld=%b idx=%0d want 1 2",
                     bus.mtr_vld, bus.mtr_idx);
        else pass_n++;
        @(negedge clk);
        tot_n++;
        if (bus.mtr_idx !== 3'd5 || bus.mtr_cmd !== mk(5) ||
            bus.dl_vld !== 8'h04)
            $display("FAIL rr_second: idx=%0d dl=%h want 5 04",
                     bus.mtr_idx, bus.dl_vld);
        else pass_n++;
        @(negedge clk);
        bus.mtr_rdy = 0;
        tot_n++;
        if (bus.dl_vld !== 8'h20 || bus.mtr_vld !== 0 || bus.occ !== 4'd7)
            $display("FAIL rr_dl5: dl=%h vld=%b occ=%0d want 20 0 7",
                     bus.dl_vld, bus.mtr_vld, bus.occ);
        else pass_n++;
        @(negedge clk);
        tot_n++;
        if (bus.dl_vld !== 8'h00 || bus.occ !== 4'd6)
            $display("FAIL rr_occ: dl=%h occ=%0d want 00 6",
                     bus.dl_vld, bus.occ);
        else pass_n++;
    endtask

    task automatic test_stall();
        int exp_idx [3] = '{2, 3, 5};
        mset = 8'b0000_1000; bus.mtr_rdy = 0;
        @(negedge clk);
        mset = '0;
        for (int c = 0; c < 4; c++) begin
            tot_n++;
            if (bus.mtr_vld !== 1 || bus.mtr_idx !== 3'd3 ||
                bus.mtr_cmd !== mk(3) || bus.dl_vld !== 8'h00)
                $display("FAIL stall_%0d: vld=%b idx=%0d dl=%h want 1 3 00",
                         c, bus.mtr_vld, bus.mtr_idx, bus.dl_vld);
            else pass_n++;
            @(negedge clk);
        end
        bus.mtr_rdy = 1;
        @(negedge clk);
        bus.mtr_rdy = 0;
        tot_n++;
        if (bus.dl_vld !== 8'h08 || bus.mtr_vld !== 0)
            $display("FAIL stall_dl: dl=%h vld=%b want 08 0",
                     bus.dl_vld, bus.mtr_vld);
        else pass_n++;
        @(negedge clk);
        tot_n++;
        if (bus.occ !== 4'd5)
            $display("FAIL stall_occ: occ=%0d want 5", bus.occ);
        else pass_n++;
        for (int k = 0; k < 3; k++) begin
            bus.in_vld = 1; bus.in_cmd = mk(exp_idx[k]);
            @(negedge clk);
            tot_n++;
            if (bus.al_vld !== 8'(1 << exp_idx[k]))
                $display("FAIL refill_%0d: al=%h want %h", k,
                         bus.al_vld, 8'(1 << exp_idx[k]));
            else pass_n++;
        end
        bus.in_vld = 0;
        tot_n++;
        if (bus.occ !== 4'd8 || bus.full !== 1)
            $display("FAIL refill_full: occ=%0d f=%b want 8 1",
                     bus.occ, bus.full);
        else pass_n++;
    endtask

    task automatic test_full_realloc();
        mset = 8'b0100_0000; bus.mtr_rdy = 1;
        @(negedge clk);
        mset = '0;
        bus.in_vld = 1; bus.in_cmd = mk(16);
        tot_n++;
        if (bus.mtr_vld !== 1 || bus.mtr_idx !== 3'd6 || bus.in_rdy !== 0)
            $display("FAIL realloc_hs: vld=%b idx=%0d rdy=%b want 1 6 0",
                     bus.mtr_vld, bus.mtr_idx, bus.in_rdy);
        else pass_n++;
        @(negedge clk);
        bus.mtr_rdy = 0;
        tot_n++;
        if (bus.dl_vld !== 8'h40 || bus.in_rdy !== 0 || bus.occ !== 4'd8)
            $display("FAIL realloc_dl: dl=%h rdy=%b occ=%0d want 40 0 8",
                     bus.dl_vld, bus.in_rdy, bus.occ);
        else pass_n++;
        @(negedge clk);
        tot_n++;
        if (bus.in_rdy !== 1 || bus.occ !== 4'd7 || bus.al_vld !== 8'h00)
            $display("FAIL realloc_free: rdy=%b occ=%0d al=%h want 1 7 00",
                     bus.in_rdy, bus.occ, bus.al_vld);
        else pass_n++;
        @(negedge clk);
        bus.in_vld = 0;
        tot_n++;
        if (bus.al_vld !== 8'h40 || bus.al_cmd_r !== mk(16) ||
            bus.occ !== 4'd8)
            $display("FAIL realloc_al: al=%h occ=%0d want 40 8",
                     bus.al_vld, bus.occ);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        mset = 8'b0000_0011; bus.mtr_rdy = 1;
        @(negedge clk);
        mset = '0;
        tot_n++;
        if (bus.mtr_vld !== 1 || bus.mtr_idx !== 3'd0)
            $display("FAIL mid_g0: vld=%b idx=%0d want 1 0",
                     bus.mtr_vld, bus.mtr_idx);
        else pass_n++;
        @(negedge clk);
        bus.mtr_rdy = 0;
        tot_n++;
        if (bus.mtr_idx !== 3'd1 || bus.dl_vld !== 8'h01)
            $display("FAIL mid_g1: idx=%0d dl=%h want 1 01",
                     bus.mtr_idx, bus.dl_vld);
        else pass_n++;
        @(negedge clk);
        bus.in_vld = 1; bus.in_cmd = mk(9);
        @(negedge clk);
        bus.in_vld = 0;
        tot_n++;
        if (bus.al_vld !== 8'h01 || bus.mtr_vld !== 1)
            $display("FAIL mid_pre: al=%h vld=%b want 01 1",
                     bus.al_vld, bus.mtr_vld);
        else pass_n++;
        rst_n = 0;
        #1;
        tot_n++;
        if (bus.al_vld !== 8'h00 || bus.dl_vld !== 8'h00 ||
            bus.mtr_vld !== 0 || bus.mtr_idx !== 3'd0 ||
            bus.mtr_cmd !== '0 || bus.al_cmd_r !== '0)
            $display("FAIL mid_rst_out: al=%h vld=%b idx=%0d want 00 0 0",
                     bus.al_vld, bus.mtr_vld, bus.mtr_idx);
        else pass_n++;
        tot_n++;
        if (bus.occ !== 4'd0 || bus.empty !== 1 || bus.full !== 0)
            $display("FAIL mid_rst_occ: occ=%0d e=%b want 0 1",
                     bus.occ, bus.empty);
        else pass_n++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mset = 8'b0001_0010;
        @(negedge clk);
        mset = '0;
        tot_n++;
        if (bus.mtr_vld !== 1 || bus.mtr_idx !== 3'd1)
            $display("FAIL mid_after: vld=%b idx=%0d want 1 1",
                     bus.mtr_vld, bus.mtr_idx);
        else pass_n++;
    endtask

    initial begin
        mset = '0;
        bus.in_vld = 0; bus.in_cmd = '0; bus.mtr_rdy = 0;
        test_reset();
        test_alloc_first();
        test_fill();
        test_rr_pair();
        test_stall();
        test_full_realloc();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
